// File: rtl/hazard_scoreboard_pkg.sv
// Purpose : shared pipeline definitions for the hazard scoreboard.
//           Provides the per-stage tracking record, the x0 register constant
//           and a helper that checks a tracked destination against live sources.
package hazard_scoreboard_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [REG_W-1:0] REG_X0 = REG_W'(0);

   // Destination tracking record for one pipeline stage.
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             memread;
   } stage_entry_t;

   localparam stage_entry_t ENTRY_BUBBLE = '0;

   // True when a nonzero destination matches either live source operand.
   function automatic logic src_hit(
      input logic [REG_W-1:0] rd,
      input logic             live1,
      input logic [REG_W-1:0] rs1,
      input logic             live2,
      input logic [REG_W-1:0] rs2
   );
      return (rd != REG_X0) && ((live1 && (rd == rs1)) || (live2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// Purpose : one shadow-pipeline stage holding a stage_entry_t.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           i_en       - advance enable (low holds the entry)
//           i_clr      - load a bubble instead of i_d when enabled
//           i_d / o_q  - entry in / registered entry out
module hazard_stage_reg
   import hazard_scoreboard_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_clr,
   input  stage_entry_t i_d,
   output stage_entry_t o_q
);

   stage_entry_t r_q;

   // Reset wins over hold; clear inserts a bubble on an advancing cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= ENTRY_BUBBLE;
      end else if (i_en) begin
         r_q <= i_clr ? ENTRY_BUBBLE : i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : in-order pipeline hazard scoreboard. Tracks destinations of the
//           ID_EX/EX_MEM/MEM_WB stages, detects load-use, branch-on-load and
//           jalr-on-ALU hazards for the instruction in ID, and drives
//           stall/bubble/flush/freeze control plus a saturating stall counter.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           id_*                     - decode fields of the instruction in ID
//           mem_stall                - cache-miss freeze request
//           mispredict               - branch resolved in ID mispredicted
//           *_rd/*_regwrite/*_memread- tracked stage state for forwarding
//           stall_pc..freeze         - pipeline control
//           stall_cnt                - saturating hazard-stall cycle count
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned XLEN_CNT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                id_valid,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                id_branch,
   input  logic                id_jalr,
   input  logic                mem_stall,
   input  logic                mispredict,
   output logic [REG_W-1:0]    ID_EX_rd,
   output logic [REG_W-1:0]    EX_MEM_rd,
   output logic [REG_W-1:0]    MEM_WB_rd,
   output logic                ID_EX_regwrite,
   output logic                EX_MEM_regwrite,
   output logic                MEM_WB_regwrite,
   output logic                ID_EX_memread,
   output logic                EX_MEM_memread,
   output logic                stall_pc,
   output logic                stall_if_id,
   output logic                bubble_id_ex,
   output logic                flush_if_id,
   output logic                freeze,
   output logic [XLEN_CNT-1:0] stall_cnt
);

   logic         w_live_rs1;
   logic         w_live_rs2;
   logic         w_hz_load;
   logic         w_hz_br;
   logic         w_hz_jalr;
   logic         w_hazard;
   logic         w_adv;
   logic         w_unused_mem_wb_memread;
   stage_entry_t w_id_ex_d;
   stage_entry_t w_id_ex_q;
   stage_entry_t w_ex_mem_q;
   stage_entry_t w_mem_wb_d;
   stage_entry_t w_mem_wb_q;

   logic [XLEN_CNT-1:0] r_stall_cnt;

   // Hazard detection against the live sources of the instruction in ID.
   assign w_live_rs1 = id_valid && id_use_rs1 && (id_rs1 != REG_X0);
   assign w_live_rs2 = id_valid && id_use_rs2 && (id_rs2 != REG_X0);

   assign w_hz_load = w_id_ex_q.memread &&
                      src_hit(w_id_ex_q.rd, w_live_rs1, id_rs1, w_live_rs2, id_rs2);
   assign w_hz_br   = (id_branch || id_jalr) && w_ex_mem_q.memread &&
                      src_hit(w_ex_mem_q.rd, w_live_rs1, id_rs1, w_live_rs2, id_rs2);
   assign w_hz_jalr = id_jalr && w_id_ex_q.regwrite &&
                      src_hit(w_id_ex_q.rd, w_live_rs1, id_rs1, 1'b0, id_rs2);
   assign w_hazard  = w_hz_load || w_hz_br || w_hz_jalr;

   // Freeze holds every stage; otherwise the shadow pipeline always shifts.
   assign w_adv = !mem_stall;

   assign w_id_ex_d  = id_valid ? stage_entry_t'{rd: id_rd, regwrite: id_regwrite,
                                                 memread: id_memread}
                                : ENTRY_BUBBLE;
   // MEM_WB never tracks a pending load.
   assign w_mem_wb_d = stage_entry_t'{rd: w_ex_mem_q.rd, regwrite: w_ex_mem_q.regwrite,
                                      memread: 1'b0};

   hazard_stage_reg u_id_ex (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_adv),
      .i_clr (w_hazard),
      .i_d   (w_id_ex_d),
      .o_q   (w_id_ex_q)
   );

   hazard_stage_reg u_ex_mem (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_adv),
      .i_clr (1'b0),
      .i_d   (w_id_ex_q),
      .o_q   (w_ex_mem_q)
   );

   hazard_stage_reg u_mem_wb (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_adv),
      .i_clr (1'b0),
      .i_d   (w_mem_wb_d),
      .o_q   (w_mem_wb_q)
   );

   assign w_unused_mem_wb_memread = w_mem_wb_q.memread;

   // Saturating count of non-frozen hazard cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_adv && w_hazard && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + XLEN_CNT'(1);
      end
   end

   // Pipeline control: freeze dominates hazard, which dominates redirect.
   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
      freeze       = mem_stall;
      if (mem_stall) begin
         stall_pc    = 1'b1;
         stall_if_id = 1'b1;
      end else if (w_hazard) begin
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
      end else begin
         flush_if_id = mispredict;
      end
   end

   assign ID_EX_rd        = w_id_ex_q.rd;
   assign ID_EX_regwrite  = w_id_ex_q.regwrite;
   assign ID_EX_memread   = w_id_ex_q.memread;
   assign EX_MEM_rd       = w_ex_mem_q.rd;
   assign EX_MEM_regwrite = w_ex_mem_q.regwrite;
   assign EX_MEM_memread  = w_ex_mem_q.memread;
   assign MEM_WB_rd       = w_mem_wb_q.rd;
   assign MEM_WB_regwrite = w_mem_wb_q.regwrite;
   assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : directed self-checking bench for hazard_scoreboard. A second
//           instance with a 4-bit counter shares the stimulus so counter
//           saturation is reached in a short run.
module tb_hazard_scoreboard;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
   logic       id_branch, id_jalr, mem_stall, mispredict;

   logic [4:0]  ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
   logic        ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite;
   logic        ID_EX_memread, EX_MEM_memread;
   logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze;
   logic [15:0] stall_cnt;

   logic [4:0]  s_id_ex_rd, s_ex_mem_rd, s_mem_wb_rd;
   logic        s_id_ex_rw, s_ex_mem_rw, s_mem_wb_rw, s_id_ex_mr, s_ex_mem_mr;
   logic        s_stall_pc, s_stall_if_id, s_bubble, s_flush, s_freeze;
   logic [3:0]  s_stall_cnt;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(.XLEN_CNT(16)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_branch(id_branch), .id_jalr(id_jalr),
      .mem_stall(mem_stall), .mispredict(mispredict),
      .ID_EX_rd(ID_EX_rd), .EX_MEM_rd(EX_MEM_rd), .MEM_WB_rd(MEM_WB_rd),
      .ID_EX_regwrite(ID_EX_regwrite), .EX_MEM_regwrite(EX_MEM_regwrite),
      .MEM_WB_regwrite(MEM_WB_regwrite),
      .ID_EX_memread(ID_EX_memread), .EX_MEM_memread(EX_MEM_memread),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
      .flush_if_id(flush_if_id), .freeze(freeze), .stall_cnt(stall_cnt)
   );

   hazard_scoreboard #(.XLEN_CNT(4)) dut_small (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_branch(id_branch), .id_jalr(id_jalr),
      .mem_stall(mem_stall), .mispredict(mispredict),
      .ID_EX_rd(s_id_ex_rd), .EX_MEM_rd(s_ex_mem_rd), .MEM_WB_rd(s_mem_wb_rd),
      .ID_EX_regwrite(s_id_ex_rw), .EX_MEM_regwrite(s_ex_mem_rw),
      .MEM_WB_regwrite(s_mem_wb_rw),
      .ID_EX_memread(s_id_ex_mr), .EX_MEM_memread(s_ex_mem_mr),
      .stall_pc(s_stall_pc), .stall_if_id(s_stall_if_id), .bubble_id_ex(s_bubble),
      .flush_if_id(s_flush), .freeze(s_freeze), .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control vector {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze}.
   task automatic chk_ctl(input string tag, input logic [4:0] exp);
      chk(tag, 32'({stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze}), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic br, input logic jr, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic rw, input logic mr);
      id_valid = 1'b1; id_branch = br; id_jalr = jr;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = mr;
      #1;
   endtask

   task automatic nop();
      id_valid = 1'b0; id_branch = 1'b0; id_jalr = 1'b0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_stall = 1'b0; mispredict = 1'b0;
      nop();
      tick();
      rst = 1'b0;
      #1;
   endtask

   // lw x5,0(x1) and add x6,x5,x1 / beq x5,x0 encodings used below.
   task automatic lw_x5();  instr(0, 0, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1); endtask
   task automatic add_x6(); instr(0, 0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0); endtask
   task automatic beq_x5(); instr(1, 0, 5'd5, 5'd0, 5'd0, 1, 1, 0, 0); endtask

   initial begin
      rst = 1'b1; mem_stall = 1'b0; mispredict = 1'b0;
      nop();
      tick();
      tick();
      // Reset state while rst is held.
      chk("rst_idex_rd", 32'(ID_EX_rd), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_small_cnt", 32'(s_stall_cnt), 32'd0);
      chk_ctl("rst_ctl", 5'b00000);
      rst = 1'b0;
      #1;

      // Load-use: lw x5 then add x6,x5,x1 stalls one cycle.
      lw_x5();
      chk_ctl("lu_lw_ctl", 5'b00000);
      tick();
      chk("lu_idex_rd", 32'(ID_EX_rd), 32'd5);
      chk("lu_idex_mr", 32'(ID_EX_memread), 32'd1);
      add_x6();
      chk_ctl("lu_stall_ctl", 5'b11100);
      tick();
      chk_ctl("lu_resume_ctl", 5'b00000);
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      chk("lu_idex_bubble", 32'(ID_EX_rd), 32'd0);
      chk("lu_exmem_rd", 32'(EX_MEM_rd), 32'd5);
      chk("lu_exmem_mr", 32'(EX_MEM_memread), 32'd1);
      tick();
      nop();
      chk("lu_idex_add_rd", 32'(ID_EX_rd), 32'd6);
      chk("lu_idex_add_rw", 32'(ID_EX_regwrite), 32'd1);
      chk("lu_memwb_rd", 32'(MEM_WB_rd), 32'd5);
      chk("lu_memwb_rw", 32'(MEM_WB_regwrite), 32'd1);

      // Branch on load: two stalls, mispredict ignored until the third cycle.
      do_reset();
      lw_x5();
      tick();
      mispredict = 1'b1;
      beq_x5();
      chk_ctl("br_stall1_ctl", 5'b11100);
      tick();
      chk_ctl("br_stall2_ctl", 5'b11100);
      chk("br_exmem_rd", 32'(EX_MEM_rd), 32'd5);
      tick();
      chk_ctl("br_flush_ctl", 5'b00010);
      chk("br_cnt", 32'(stall_cnt), 32'd2);
      tick();
      mispredict = 1'b0;
      nop();
      chk_ctl("br_after_ctl", 5'b00000);

      // jalr on an ALU result stalls once; x0 writer causes no stall.
      do_reset();
      instr(0, 0, 5'd1, 5'd2, 5'd7, 1, 1, 1, 0);
      tick();
      instr(0, 1, 5'd7, 5'd0, 5'd0, 1, 0, 1, 0);
      chk_ctl("jr_stall_ctl", 5'b11100);
      tick();
      chk_ctl("jr_resume_ctl", 5'b00000);
      chk("jr_cnt", 32'(stall_cnt), 32'd1);
      tick();
      instr(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0);
      tick();
      instr(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0);
      chk_ctl("jr_x0_ctl", 5'b00000);
      tick();
      chk("jr_x0_cnt", 32'(stall_cnt), 32'd1);

      // Freeze during load-use holds state and counter.
      do_reset();
      lw_x5();
      tick();
      mem_stall = 1'b1;
      add_x6();
      chk_ctl("fz_ctl", 5'b11001);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fz_idex_rd", 32'(ID_EX_rd), 32'd5);
         chk("fz_exmem_rd", 32'(EX_MEM_rd), 32'd0);
         chk("fz_cnt", 32'(stall_cnt), 32'd0);
         chk_ctl("fz_hold_ctl", 5'b11001);
      end
      mem_stall = 1'b0;
      #1;
      chk_ctl("fz_release_ctl", 5'b11100);
      tick();
      chk("fz_after_cnt", 32'(stall_cnt), 32'd1);
      chk("fz_after_exmem", 32'(EX_MEM_rd), 32'd5);
      chk("fz_after_idex", 32'(ID_EX_rd), 32'd0);
      chk_ctl("fz_after_ctl", 5'b00000);

      // Reset in the middle of a two-cycle branch stall.
      do_reset();
      lw_x5();
      tick();
      beq_x5();
      chk_ctl("rb_stall1_ctl", 5'b11100);
      tick();
      chk_ctl("rb_stall2_ctl", 5'b11100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rb_idex_rd", 32'(ID_EX_rd), 32'd0);
      chk("rb_exmem_rd", 32'(EX_MEM_rd), 32'd0);
      chk("rb_memwb_rd", 32'(MEM_WB_rd), 32'd0);
      chk("rb_cnt", 32'(stall_cnt), 32'd0);
      chk_ctl("rb_ctl", 5'b00000);

      // Repeated branch-on-load: 2 stalls per iteration; 4-bit counter saturates.
      do_reset();
      for (int it = 0; it < 10; it++) begin
         lw_x5();
         tick();
         beq_x5();
         tick();
         tick();
         if (it == 6) chk("sat_small_14", 32'(s_stall_cnt), 32'd14);
      end
      chk("sat_big_cnt", 32'(stall_cnt), 32'd20);
      chk("sat_small_cnt", 32'(s_stall_cnt), 32'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
